// File: rtl/pipelined_barrel_shifter.sv
// Pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with shifter carry-out.
// Elastic valid/ready pipeline, STAGES register stages deep, carrying an opaque tag.
// Optional synchronous pipeline flush port enabled by defining SHIFTER_FLUSH_EN.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef SHIFTER_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         register,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [1:0]               sh,
  input  logic                     carry_in,
  input  logic [TAG_W-1:0]         tag_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     carry_out,
  output logic [TAG_W-1:0]         tag_out
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  localparam logic [WIDTH-1:0] LsbOne = {{(WIDTH-1){1'b0}}, 1'b1};

  // LSL is computed as a right shift of the bit-reversed operand, then reversed back.
  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

  // One log-shifter level: right shift by n with fill chosen by shift type.
  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] d,
                                                   input int unsigned      n,
                                                   input logic [1:0]       kind);
    logic [WIDTH-1:0] r;
    unique case (kind)
      ShRor:   r = (d >> n) | (d << (WIDTH - n));
      ShAsr:   r = $signed(d) >>> n;
      default: r = d >> n;
    endcase
    return r;
  endfunction

  logic flush_w;

`ifdef SHIFTER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              carry_q, carry_d;
    logic [1:0]        sh_q, sh_d;
    logic [LEVELS-1:0] shamt_q, shamt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              adv;

    logic              up_valid;
    logic [WIDTH-1:0]  up_data;
    logic              up_carry;
    logic [1:0]        up_sh;
    logic [LEVELS-1:0] up_shamt;
    logic [TAG_W-1:0]  up_tag;

    logic [WIDTH-1:0]  shf_data;
    logic              shf_carry;

    if (s == 0) begin : g_src
      assign up_valid = in_valid & in_ready;
      assign up_data  = (sh == ShLsl) ? bit_reverse(register) : register;
      assign up_carry = carry_in;
      assign up_sh    = sh;
      assign up_shamt = shamt;
      assign up_tag   = tag_in;
    end else begin : g_src
      assign up_valid = g_stage[s-1].valid_q;
      assign up_data  = g_stage[s-1].data_q;
      assign up_carry = g_stage[s-1].carry_q;
      assign up_sh    = g_stage[s-1].sh_q;
      assign up_shamt = g_stage[s-1].shamt_q;
      assign up_tag   = g_stage[s-1].tag_q;
    end

    if (s == STAGES - 1) begin : g_adv
      assign adv = ~valid_q | out_ready;
    end else begin : g_adv
      assign adv = ~valid_q | g_stage[s+1].adv;
    end

    // Apply the log-shifter levels owned by this stage; carry tracks the last bit shifted out.
    always_comb begin
      shf_data  = up_data;
      shf_carry = up_carry;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        if ((k * STAGES) / LEVELS == int'(s) && up_shamt[k]) begin
          shf_carry = |(shf_data & (LsbOne << ((1 << k) - 1)));
          shf_data  = shift_right(shf_data, 1 << k, up_sh);
        end
      end
      if (s == STAGES - 1) begin
        if (up_sh == ShLsl) begin
          shf_data = bit_reverse(shf_data);
        end else if (up_sh == ShRor && up_shamt == '0) begin
          // RRX: rotate right by one through the incoming C flag.
          shf_carry = shf_data[0];
          shf_data  = {up_carry, shf_data[WIDTH-1:1]};
        end
      end
    end

    // Next-state: flush beats advance; data only loads when a valid op moves in.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      carry_d = carry_q;
      sh_d    = sh_q;
      shamt_d = shamt_q;
      tag_d   = tag_q;
      if (flush_w) begin
        valid_d = 1'b0;
      end else if (adv) begin
        valid_d = up_valid;
      end
      if (adv && up_valid) begin
        data_d  = shf_data;
        carry_d = shf_carry;
        sh_d    = up_sh;
        shamt_d = up_shamt;
        tag_d   = up_tag;
      end
    end

    // Stage registers, cleared asynchronously so in-flight ops are discarded on reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        carry_q <= 1'b0;
        sh_q    <= '0;
        shamt_q <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        carry_q <= carry_d;
        sh_q    <= sh_d;
        shamt_q <= shamt_d;
        tag_q   <= tag_d;
      end
    end
  end

  assign in_ready  = g_stage[0].adv & ~flush_w;
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign result    = g_stage[STAGES-1].data_q;
  assign carry_out = g_stage[STAGES-1].carry_q;
  assign tag_out   = g_stage[STAGES-1].tag_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32, STAGES=2, TAG_W=4).
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] register;
  logic [4:0]  shamt;
  logic [1:0]  sh;
  logic        carry_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic [3:0]  tag_out;
`ifdef SHIFTER_FLUSH_EN
  logic        flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(
    .WIDTH (32),
    .STAGES(2),
    .TAG_W (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef SHIFTER_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .register (register),
    .shamt    (shamt),
    .sh       (sh),
    .carry_in (carry_in),
    .tag_in   (tag_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry_out(carry_out),
    .tag_out  (tag_out)
  );

  // Reference model written directly from the ARM shifter rules.
  function automatic void model(input logic [31:0] r, input logic [4:0] n, input logic [1:0] s,
                                input logic c, output logic [31:0] res, output logic co);
    logic [32:0] ext;
    case (s)
      2'b00: begin
        ext = {1'b0, r} << n;
        res = ext[31:0];
        co  = (n != 0) ? ext[32] : c;
      end
      2'b01: begin
        ext = {r, 1'b0} >> n;
        res = ext[32:1];
        co  = (n != 0) ? ext[0] : c;
      end
      2'b10: begin
        ext = $signed({r, 1'b0}) >>> n;
        res = ext[32:1];
        co  = (n != 0) ? ext[0] : c;
      end
      default: begin
        if (n != 0) begin
          res = (r >> n) | (r << (32 - n));
          co  = res[31];
        end else begin
          res = {c, r[31:1]};
          co  = r[0];
        end
      end
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (result !== 32'h0 || carry_out !== 1'b0 || tag_out !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got result=%h carry=%b tag=%h expected 0/0/0",
               result, carry_out, tag_out);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  // Single op with no backpressure: result must appear exactly two edges after acceptance.
  task automatic run_vec(input string name, input logic [31:0] r, input logic [4:0] n,
                         input logic [1:0] s, input logic c, input logic [3:0] t,
                         input logic [31:0] er, input logic ec);
    out_ready = 1'b1;
    register  = r;
    shamt     = n;
    sh        = s;
    carry_in  = c;
    tag_in    = t;
    in_valid  = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s early_valid: got %b expected 0", name, out_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || tag_out !== t) begin
      n_fail++;
      $display("FAIL %s valid_tag: got valid=%b tag=%h expected 1/%h", name, out_valid, tag_out, t);
    end
    n_checks++;
    if (result !== er) begin
      n_fail++; $display("FAIL %s result: got %h expected %h", name, result, er);
    end
    n_checks++;
    if (carry_out !== ec) begin
      n_fail++; $display("FAIL %s carry: got %b expected %b", name, carry_out, ec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_vec("lsl1",     32'h8000_0001, 5'd1,  2'b00, 1'b0, 4'h1, 32'h0000_0002, 1'b1);
    run_vec("asr4",     32'h8000_0000, 5'd4,  2'b10, 1'b0, 4'h2, 32'hF800_0000, 1'b0);
    run_vec("lsr4",     32'h8000_0000, 5'd4,  2'b01, 1'b0, 4'h3, 32'h0800_0000, 1'b0);
    run_vec("ror8",     32'h1234_5678, 5'd8,  2'b11, 1'b0, 4'h4, 32'h7812_3456, 1'b0);
    run_vec("rrx",      32'h0000_0003, 5'd0,  2'b11, 1'b1, 4'h5, 32'h8000_0001, 1'b1);
    run_vec("lsl0",     32'hA5A5_A5A5, 5'd0,  2'b00, 1'b1, 4'h6, 32'hA5A5_A5A5, 1'b1);
    run_vec("asr0",     32'h8000_0000, 5'd0,  2'b10, 1'b0, 4'h7, 32'h8000_0000, 1'b0);
    run_vec("lsr31",    32'h8000_0000, 5'd31, 2'b01, 1'b1, 4'h8, 32'h0000_0001, 1'b0);
    run_vec("asr31",    32'h8000_0000, 5'd31, 2'b10, 1'b1, 4'h9, 32'hFFFF_FFFF, 1'b0);
    run_vec("lsl31",    32'hFFFF_FFFF, 5'd31, 2'b00, 1'b0, 4'hA, 32'h8000_0000, 1'b1);
    run_vec("ror1",     32'h0000_0001, 5'd1,  2'b11, 1'b0, 4'hB, 32'h8000_0000, 1'b1);
    run_vec("ror31",    32'h8000_0000, 5'd31, 2'b11, 1'b1, 4'hC, 32'h0000_0001, 1'b0);
    run_vec("lsr29",    32'hF000_0000, 5'd29, 2'b01, 1'b0, 4'hD, 32'h0000_0007, 1'b1);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    sh        = 2'b00;
    shamt     = 5'd1;
    carry_in  = 1'b0;
    register  = 32'd1;
    tag_in    = 4'd1;
    in_valid  = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept1: got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    register = 32'd2;
    tag_in   = 4'd2;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept2: got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    register = 32'd3;
    tag_in   = 4'd3;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall_ready: cycle %0d got %b expected 0", i, in_ready);
      end
      n_checks++;
      if (out_valid !== 1'b1 || tag_out !== 4'd1 || result !== 32'd2) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d got valid=%b tag=%h result=%h expected 1/1/00000002",
                 i, out_valid, tag_out, result);
      end
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || tag_out !== 4'd2 || result !== 32'd4) begin
      n_fail++;
      $display("FAIL bp_drain2: got valid=%b tag=%h result=%h expected 1/2/00000004",
               out_valid, tag_out, result);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || tag_out !== 4'd3 || result !== 32'd6) begin
      n_fail++;
      $display("FAIL bp_drain3: got valid=%b tag=%h result=%h expected 1/3/00000006",
               out_valid, tag_out, result);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] q_res[$];
    logic        q_c[$];
    logic [3:0]  q_t[$];
    logic [31:0] r, er;
    logic [4:0]  n;
    logic [1:0]  s;
    logic        c, ec;
    logic [3:0]  t;
    int          sent = 0;
    int          got  = 0;
    int          gaps = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 110; cyc++) begin
      if (out_valid === 1'b1) begin
        if (q_res.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_extra: got unexpected tag=%h expected none", tag_out);
        end else begin
          er = q_res.pop_front();
          ec = q_c.pop_front();
          t  = q_t.pop_front();
          n_checks++;
          if (result !== er) begin
            n_fail++; $display("FAIL stream_result #%0d: got %h expected %h", got, result, er);
          end
          n_checks++;
          if (carry_out !== ec) begin
            n_fail++; $display("FAIL stream_carry #%0d: got %b expected %b", got, carry_out, ec);
          end
          n_checks++;
          if (tag_out !== t) begin
            n_fail++; $display("FAIL stream_tag #%0d: got %h expected %h", got, tag_out, t);
          end
          got++;
        end
      end else if (got > 0 && got < 100) begin
        gaps++;
      end
      if (sent < 100) begin
        r = $urandom();
        n = (sent % 5 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        s = 2'($urandom_range(0, 3));
        c = 1'($urandom_range(0, 1));
        t = 4'(sent);
        model(r, n, s, c, er, ec);
        register = r;
        shamt    = n;
        sh       = s;
        carry_in = c;
        tag_in   = t;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL stream_in_ready #%0d: got %b expected 1", sent, in_ready);
        end
        q_res.push_back(er);
        q_c.push_back(ec);
        q_t.push_back(t);
        sent++;
      end else begin
        in_valid = 1'b0;
        #1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 100) begin
      n_fail++; $display("FAIL stream_count: got %0d results expected 100", got);
    end
    n_checks++;
    if (gaps != 0) begin
      n_fail++; $display("FAIL stream_gaps: got %0d bubbles expected 0", gaps);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    sh        = 2'b00;
    shamt     = 5'd1;
    carry_in  = 1'b0;
    register  = 32'd5;
    tag_in    = 4'd5;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    register = 32'd6;
    tag_in   = 4'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || tag_out !== 4'h0) begin
      n_fail++;
      $display("FAIL midreset_clear: got valid=%b result=%h tag=%h expected 0/0/0",
               out_valid, result, tag_out);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: got in_ready=%b valid=%b expected 1/0", in_ready, out_valid);
    end
    register = 32'h8000_0000;
    shamt    = 5'd4;
    sh       = 2'b10;
    tag_in   = 4'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_latency1: got valid=%b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'hF800_0000 || tag_out !== 4'd7) begin
      n_fail++;
      $display("FAIL midreset_first: got valid=%b result=%h tag=%h expected 1/f8000000/7",
               out_valid, result, tag_out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_stale: got valid=%b tag=%h expected 0", out_valid, tag_out);
    end
  endtask

`ifdef SHIFTER_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b0;
    sh        = 2'b01;
    shamt     = 5'd2;
    carry_in  = 1'b0;
    register  = 32'h100;
    tag_in    = 4'd8;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    tag_in = 4'd9;
    @(posedge clk);
    #1;
    tag_in = 4'd10;
    flush  = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got valid=%b expected 0", out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_leak: cycle %0d got valid=%b tag=%h expected 0",
                           i, out_valid, tag_out);
      end
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    register  = 32'h0;
    shamt     = 5'd0;
    sh        = 2'b00;
    carry_in  = 1'b0;
    tag_in    = 4'h0;
`ifdef SHIFTER_FLUSH_EN
    flush     = 1'b0;
`endif
    test_reset();
    test_directed();
    test_backpressure();
    test_streaming();
    test_reset_mid();
`ifdef SHIFTER_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the datapath's combinational ARM shifter.
- Performs LSL/LSR/ASR/ROR plus ARM-style RRX (ROR #0), and produces a shifter carry-out.
- Uses a valid/ready elastic pipeline and carries a passthrough tag.
- Sits between the register-file read operand and the ALU B input in the multi-cycle/pipelined core.

Parameters:
- WIDTH, 32, operand/result width in bits; power of 2, >= 8.
- STAGES, 2, number of register stages (1..$clog2(WIDTH)); this is also the latency in cycles.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the shifter accepts the operation this cycle.
- register  in  WIDTH  operand to shift.
- shamt  in  $clog2(WIDTH)  shift amount.
- sh  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX.
- carry_in  in  1  current C flag.
- tag_in  in  TAG_W  opaque tag.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  shifted value.
- carry_out  out  1  shifter carry.
- tag_out  out  TAG_W  tag of the current result.

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, out_valid, result, carry_out and tag_out clear to 0 immediately. in_ready=1 from the first cycle after release.
- Transfer rule: an input is accepted when in_valid & in_ready; an output is consumed when out_valid & out_ready.
- Elastic pipeline: stage i advances when stage i+1 is empty or advancing. The last stage advances when out_ready=1 or when it is empty. in_ready = !valid[0] | advance[0], which is combinational from out_ready.
- Full throughput: 1 op/cycle when out_ready=1. Latency is exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
- Stall: while out_valid & !out_ready, result, carry_out and tag_out hold stable. No op is lost or duplicated, and ordering is preserved.
- Datapath: log-shifter with $clog2(WIDTH) levels, bit k of shamt in level k. Level k is placed in stage floor(k*STAGES/$clog2(WIDTH)). sh, carry_in, the original operand bits needed for carry, and tag travel with the data.
- Result and carry rules, n = shamt:
  - LSL: result = register << n. carry = register[WIDTH-n] if n>0, else carry_in.
  - LSR: result = register >> n (zero fill). carry = register[n-1] if n>0, else carry_in.
  - ASR: result is register shifted right by n with the sign bit replicated. carry = register[n-1] if n>0, else carry_in.
  - ROR, n>0: result = (register >> n) | (register << (WIDTH-n)). carry = result[WIDTH-1].
  - ROR, n=0 (RRX): result = {carry_in, register[WIDTH-1:1]}. carry = register[0].
- n=0 on LSL/LSR/ASR passes register through unchanged.
- There is no illegal sh encoding; all four codes are defined.
- Simultaneous accept and consume on a full pipeline is legal and sustains full throughput.
- Reset asserted mid-operation discards all in-flight ops.

Optional Feature:
- Macro: SHIFTER_FLUSH_EN.
- When defined: adds input port flush (1 bit, synchronous). flush=1 clears every stage valid bit on the next edge, and out_valid=0 in the following cycle. Data registers may hold stale values. An in_valid presented in the same cycle as flush is not accepted (in_ready=0 while flush=1). Flush has priority over advance.
- When undefined: there is no flush port, and in-flight ops are removed only by reset.

Test Plan:
- WIDTH=32, STAGES=2, LSL: register=0x8000_0001, shamt=1, carry_in=0 -> two cycles later result=0x0000_0002, carry_out=1.
- ASR: register=0x8000_0000, shamt=4 -> result=0xF800_0000, carry_out=0. LSR with the same inputs -> result=0x0800_0000, carry_out=0.
- ROR: register=0x1234_5678, shamt=8 -> result=0x7812_3456, carry_out=0. RRX (sh=11, shamt=0, carry_in=1, register=0x0000_0003) -> result=0x8000_0001, carry_out=1.
- Backpressure: issue tags 1,2,3 back-to-back with out_ready=0 -> in_ready drops after 2 accepts, and outputs hold tag 1. Release out_ready -> tags 1,2,3 appear in order, no gaps or duplicates.
- Streaming: 100 random ops with out_ready=1 -> one result per cycle, each matching the golden model, including the shamt=0 carry_in passthrough cases.
- Reset mid-stream: drive reset=0 asynchronously with 2 ops in flight -> out_valid=0 before the next edge. After release, in_ready=1 and the first new op emerges 2 cycles after acceptance.
- (With SHIFTER_FLUSH_EN) flush with 2 ops in flight -> out_valid=0 the next cycle, and neither op is ever output.
